sm4_key_expand: RTL and testbench

SM4_KEY_EXPAND -- requirements
Module: sm4_key_expand

---
 rtl/sm4_pkg.sv | 42 ++++
 rtl/sm4_key_round.sv | 25 ++
 rtl/sm4_key_expand.sv | 177 +++++++++++++++++
 tb/tb_sm4_key_expand.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants: S-box, FK words, CK generator and
// the key-expansion state encoding.
package sm4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } kx_state_t;

    localparam logic [127:0] FK = {32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // CK_i byte j (byte 0 is the most significant) = (4i+j)*7 mod 256.
    function automatic logic [31:0] ck_gen(input logic [4:0] i);
        logic [31:0] ck;
        ck = '0;
        for (int j = 0; j < 4; j++) begin
            ck[31-8*j -: 8] = 8'(((4 * int'(i) + j) * 7) % 256);
        end
        return ck;
    endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One SM4 key-schedule round: rk = K0 ^ T'(K1 ^ K2 ^ K3 ^ CK), purely combinational.
module sm4_key_round
    import sm4_pkg::*;
(
    input  logic [127:0] i_k,
    input  logic [31:0]  i_ck,
    output logic [31:0]  o_rk
);

    logic [31:0] w_x;
    logic [31:0] w_b;

    assign w_x = i_k[95:64] ^ i_k[63:32] ^ i_k[31:0] ^ i_ck;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_b[8*gi +: 8] = SBOX[w_x[8*gi +: 8]];
        end
    endgenerate

    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    assign o_rk = i_k[127:96] ^ w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};

endmodule

// File: rtl/sm4_key_expand.sv
// SM4 round-key expansion, ROUNDS_PER_CYCLE rounds per enabled clock.
// Define SM4_KEY_ZEROIZE_EN to wipe K and all round keys on an abort.
module sm4_key_expand
    import sm4_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sm4_enable_in,
    input  logic         key_exp_enable_in,
    input  logic         key_load_in,
    input  logic         decrypt_in,
    input  logic [127:0] key_in,
    output logic [31:0]  rk_00_out, output logic [31:0] rk_01_out,
    output logic [31:0]  rk_02_out, output logic [31:0] rk_03_out,
    output logic [31:0]  rk_04_out, output logic [31:0] rk_05_out,
    output logic [31:0]  rk_06_out, output logic [31:0] rk_07_out,
    output logic [31:0]  rk_08_out, output logic [31:0] rk_09_out,
    output logic [31:0]  rk_10_out, output logic [31:0] rk_11_out,
    output logic [31:0]  rk_12_out, output logic [31:0] rk_13_out,
    output logic [31:0]  rk_14_out, output logic [31:0] rk_15_out,
    output logic [31:0]  rk_16_out, output logic [31:0] rk_17_out,
    output logic [31:0]  rk_18_out, output logic [31:0] rk_19_out,
    output logic [31:0]  rk_20_out, output logic [31:0] rk_21_out,
    output logic [31:0]  rk_22_out, output logic [31:0] rk_23_out,
    output logic [31:0]  rk_24_out, output logic [31:0] rk_25_out,
    output logic [31:0]  rk_26_out, output logic [31:0] rk_27_out,
    output logic [31:0]  rk_28_out, output logic [31:0] rk_29_out,
    output logic [31:0]  rk_30_out, output logic [31:0] rk_31_out,
    output logic         key_exp_ready_out
);

    kx_state_t    r_state;
    kx_state_t    r_state_next;
    logic [4:0]   r_round;
    logic [127:0] r_k;
    logic         r_decrypt;
    logic [31:0]  r_rk [32];

    logic         w_start;
    logic         w_expand;
    logic         w_abort;
    logic         w_last;
    logic [127:0] w_knext;
    logic [31:0]  w_rk_all   [ROUNDS_PER_CYCLE];
    logic [4:0]   w_slot_all [ROUNDS_PER_CYCLE];

    // Each stage consumes the previous stage's shifted K window.
    genvar gi;
    generate
        for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
            logic [127:0] w_kin;
            logic [127:0] w_kout;
            logic [31:0]  w_rk;
            logic [31:0]  w_ck;
            logic [4:0]   w_idx;

            if (gi == 0) begin : g_first
                assign w_kin = r_k;
            end else begin : g_chain
                assign w_kin = g_round[gi-1].w_kout;
            end

            assign w_idx = r_round + 5'(gi);
            assign w_ck  = ck_gen(w_idx);

            sm4_key_round u_round (
                .i_k  (w_kin),
                .i_ck (w_ck),
                .o_rk (w_rk)
            );

            assign w_kout         = {w_kin[95:0], w_rk};
            assign w_rk_all[gi]   = w_rk;
            assign w_slot_all[gi] = r_decrypt ? ~w_idx : w_idx;
        end
    endgenerate

    assign w_knext = g_round[ROUNDS_PER_CYCLE-1].w_kout;
    assign w_last  = (r_round == 5'(32 - ROUNDS_PER_CYCLE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        w_start      = 1'b0;
        w_expand     = 1'b0;
        w_abort      = 1'b0;
        if (sm4_enable_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (key_exp_enable_in && key_load_in) begin
                        w_start      = 1'b1;
                        r_state_next = ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    if (!key_exp_enable_in) begin
                        w_abort      = 1'b1;
                        r_state_next = ST_IDLE;
                    end else begin
                        w_expand = 1'b1;
                        if (w_last) begin
                            r_state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!key_exp_enable_in) begin
                        w_abort      = 1'b1;
                        r_state_next = ST_IDLE;
                    end else if (key_load_in) begin
                        w_start      = 1'b1;
                        r_state_next = ST_EXPAND;
                    end
                end
                default: r_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_round   <= '0;
            r_k       <= '0;
            r_decrypt <= 1'b0;
            for (int s = 0; s < 32; s++) begin
                r_rk[s] <= '0;
            end
        end else if (w_start) begin
            r_round   <= '0;
            r_k       <= key_in ^ FK;
            r_decrypt <= decrypt_in;
        end else if (w_expand) begin
            for (int g = 0; g < ROUNDS_PER_CYCLE; g++) begin
                r_rk[w_slot_all[g]] <= w_rk_all[g];
            end
            r_k     <= w_knext;
            r_round <= r_round + 5'(ROUNDS_PER_CYCLE);
        end else if (w_abort) begin
            r_round <= '0;
`ifdef SM4_KEY_ZEROIZE_EN
            r_k <= '0;
            for (int s = 0; s < 32; s++) begin
                r_rk[s] <= '0;
            end
`endif
        end
    end

    assign key_exp_ready_out = (r_state == ST_DONE);

    assign rk_00_out = r_rk[0];  assign rk_01_out = r_rk[1];
    assign rk_02_out = r_rk[2];  assign rk_03_out = r_rk[3];
    assign rk_04_out = r_rk[4];  assign rk_05_out = r_rk[5];
    assign rk_06_out = r_rk[6];  assign rk_07_out = r_rk[7];
    assign rk_08_out = r_rk[8];  assign rk_09_out = r_rk[9];
    assign rk_10_out = r_rk[10]; assign rk_11_out = r_rk[11];
    assign rk_12_out = r_rk[12]; assign rk_13_out = r_rk[13];
    assign rk_14_out = r_rk[14]; assign rk_15_out = r_rk[15];
    assign rk_16_out = r_rk[16]; assign rk_17_out = r_rk[17];
    assign rk_18_out = r_rk[18]; assign rk_19_out = r_rk[19];
    assign rk_20_out = r_rk[20]; assign rk_21_out = r_rk[21];
    assign rk_22_out = r_rk[22]; assign rk_23_out = r_rk[23];
    assign rk_24_out = r_rk[24]; assign rk_25_out = r_rk[25];
    assign rk_26_out = r_rk[26]; assign rk_27_out = r_rk[27];
    assign rk_28_out = r_rk[28]; assign rk_29_out = r_rk[29];
    assign rk_30_out = r_rk[30]; assign rk_31_out = r_rk[31];

endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand (one- and four-rounds-per-cycle instances)
// against a recursive key-schedule model and SM4 known-answer vectors.
module tb_sm4_key_expand;
    import sm4_pkg::*;

    localparam logic [127:0] KAT_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681EDF34D206965E86B3E94F536E4246;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         kee = 1'b0;
    logic         load = 1'b0;
    logic         dec = 1'b0;
    logic [127:0] key = '0;
    logic [31:0]  rk1 [32];
    logic [31:0]  rk4 [32];
    logic         rdy1;
    logic         rdy4;
    logic [31:0]  m_rk [32];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    sm4_key_expand #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .sm4_enable_in(en), .key_exp_enable_in(kee),
        .key_load_in(load), .decrypt_in(dec), .key_in(key),
        .rk_00_out(rk1[0]),  .rk_01_out(rk1[1]),  .rk_02_out(rk1[2]),  .rk_03_out(rk1[3]),
        .rk_04_out(rk1[4]),  .rk_05_out(rk1[5]),  .rk_06_out(rk1[6]),  .rk_07_out(rk1[7]),
        .rk_08_out(rk1[8]),  .rk_09_out(rk1[9]),  .rk_10_out(rk1[10]), .rk_11_out(rk1[11]),
        .rk_12_out(rk1[12]), .rk_13_out(rk1[13]), .rk_14_out(rk1[14]), .rk_15_out(rk1[15]),
        .rk_16_out(rk1[16]), .rk_17_out(rk1[17]), .rk_18_out(rk1[18]), .rk_19_out(rk1[19]),
        .rk_20_out(rk1[20]), .rk_21_out(rk1[21]), .rk_22_out(rk1[22]), .rk_23_out(rk1[23]),
        .rk_24_out(rk1[24]), .rk_25_out(rk1[25]), .rk_26_out(rk1[26]), .rk_27_out(rk1[27]),
        .rk_28_out(rk1[28]), .rk_29_out(rk1[29]), .rk_30_out(rk1[30]), .rk_31_out(rk1[31]),
        .key_exp_ready_out(rdy1)
    );

    sm4_key_expand #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .sm4_enable_in(en), .key_exp_enable_in(kee),
        .key_load_in(load), .decrypt_in(dec), .key_in(key),
        .rk_00_out(rk4[0]),  .rk_01_out(rk4[1]),  .rk_02_out(rk4[2]),  .rk_03_out(rk4[3]),
        .rk_04_out(rk4[4]),  .rk_05_out(rk4[5]),  .rk_06_out(rk4[6]),  .rk_07_out(rk4[7]),
        .rk_08_out(rk4[8]),  .rk_09_out(rk4[9]),  .rk_10_out(rk4[10]), .rk_11_out(rk4[11]),
        .rk_12_out(rk4[12]), .rk_13_out(rk4[13]), .rk_14_out(rk4[14]), .rk_15_out(rk4[15]),
        .rk_16_out(rk4[16]), .rk_17_out(rk4[17]), .rk_18_out(rk4[18]), .rk_19_out(rk4[19]),
        .rk_20_out(rk4[20]), .rk_21_out(rk4[21]), .rk_22_out(rk4[22]), .rk_23_out(rk4[23]),
        .rk_24_out(rk4[24]), .rk_25_out(rk4[25]), .rk_26_out(rk4[26]), .rk_27_out(rk4[27]),
        .rk_28_out(rk4[28]), .rk_29_out(rk4[29]), .rk_30_out(rk4[30]), .rk_31_out(rk4[31]),
        .key_exp_ready_out(rdy4)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int j = 0; j < 4; j++) y[8*j +: 8] = SBOX[x[8*j +: 8]];
        return y;
    endfunction

    function automatic logic [31:0] ck_ref(input int i);
        logic [31:0] c;
        c = '0;
        for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return c;
    endfunction

    // Textbook recursion K[i+4] = K[i] ^ T'(...); writes the first nr round keys into m_rk.
    task automatic model_rounds(input logic [127:0] k_in, input logic d, input int nr);
        logic [31:0]  kw [36];
        logic [127:0] kx;
        logic [31:0]  t;
        kx = k_in ^ 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
        for (int j = 0; j < 4; j++) kw[j] = kx[127-32*j -: 32];
        for (int i = 0; i < nr; i++) begin
            t = tau(kw[i+1] ^ kw[i+2] ^ kw[i+3] ^ ck_ref(i));
            kw[i+4] = kw[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            m_rk[d ? 31 - i : i] = kw[i+4];
        end
    endtask

    // SM4 block cipher using dut1's round keys in slot order.
    function automatic logic [127:0] sm4_crypt(input logic [127:0] blk);
        logic [31:0] x [36];
        logic [31:0] b;
        for (int j = 0; j < 4; j++) x[j] = blk[127-32*j -: 32];
        for (int i = 0; i < 32; i++) begin
            b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk1[i]);
            x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic use4);
        int          bad;
        logic [31:0] v;
        bad = -1;
        v   = '0;
        for (int s = 0; s < 32; s++) begin
            if ((use4 ? rk4[s] : rk1[s]) !== m_rk[s] && bad < 0) begin
                bad = s;
                v   = use4 ? rk4[s] : rk1[s];
            end
        end
        checks++;
        assert (bad === -1) else begin
            errors++;
            $error("FAIL %s slot=%0d observed=%h expected=%h", tag, bad, v, m_rk[bad]);
        end
    endtask

    task automatic start(input logic [127:0] k, input logic d);
        key  = k;
        dec  = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (rdy1 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        int           n4;
        logic [127:0] rk_a;
        logic         d_a;

        // Reset state
        tick();
        tick();
        for (int s = 0; s < 32; s++) m_rk[s] = '0;
        chk("reset_ready1", 128'(rdy1), 128'(0));
        chk("reset_ready4", 128'(rdy4), 128'(0));
        chk_all("reset_rk1", 1'b0);
        chk_all("reset_rk4", 1'b1);
        reset_n = 1'b1;
        en      = 1'b1;
        kee     = 1'b1;
        tick();

        // Encrypt known answer on both instances
        start(KAT_KEY, 1'b0);
        model_rounds(KAT_KEY, 1'b0, 32);
        n  = 0;
        n4 = -1;
        while (rdy1 !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (rdy4 === 1'b1 && n4 < 0) n4 = n;
        end
        chk("enc_latency1", 128'(n), 128'(32));
        chk("enc_latency4", 128'(n4), 128'(8));
        chk("enc_rk00", 128'(rk1[0]), 128'(32'hF12186F9));
        chk("enc_rk01", 128'(rk1[1]), 128'(32'h41662B61));
        chk("enc_rk31", 128'(rk1[31]), 128'(32'h9124A012));
        chk("enc4_rk00", 128'(rk4[0]), 128'(32'hF12186F9));
        chk_all("enc_all1", 1'b0);
        chk_all("enc_all4", 1'b1);

        // Abort from DONE
        kee = 1'b0;
        tick();
        chk("done_abort_ready", 128'(rdy1), 128'(0));
`ifdef SM4_KEY_ZEROIZE_EN
        for (int s = 0; s < 32; s++) m_rk[s] = '0;
`endif
        chk_all("done_abort_rk", 1'b0);
        kee = 1'b1;
        tick();

        // Decrypt known answer, then decrypt the reference ciphertext with it
        start(KAT_KEY, 1'b1);
        model_rounds(KAT_KEY, 1'b1, 32);
        wait_ready(n);
        chk("dec_latency", 128'(n), 128'(32));
        chk("dec_rk00", 128'(rk1[0]), 128'(32'h9124A012));
        chk("dec_rk31", 128'(rk1[31]), 128'(32'hF12186F9));
        chk_all("dec_all", 1'b0);
        chk("dec_plaintext", sm4_crypt(KAT_CT), KAT_KEY);

        // Restart from DONE, stall for 5 cycles at round 10
        start(KAT_KEY, 1'b0);
        chk("restart_ready_drop", 128'(rdy1), 128'(0));
        chk_all("restart_rk_persist", 1'b0);
        for (int c = 0; c < 10; c++) tick();
        model_rounds(KAT_KEY, 1'b0, 10);
        chk_all("stall_entry", 1'b0);
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            load = c[0];
            kee  = ~c[0];
            key  = rand128();
            tick();
            chk("stall_ready", 128'(rdy1), 128'(0));
            chk_all("stall_frozen", 1'b0);
        end
        en   = 1'b1;
        kee  = 1'b1;
        load = 1'b0;
        wait_ready(n);
        chk("stall_latency", 128'(n), 128'(22));
        model_rounds(KAT_KEY, 1'b0, 32);
        chk_all("stall_all", 1'b0);

        // Abort mid-EXPAND at round 16, then confirm IDLE holds
        start(KAT_KEY, 1'b0);
        for (int c = 0; c < 16; c++) tick();
        kee = 1'b0;
        tick();
        chk("abort_ready", 128'(rdy1), 128'(0));
`ifdef SM4_KEY_ZEROIZE_EN
        chk("abort_rk00", 128'(rk1[0]), 128'(0));
        for (int s = 0; s < 32; s++) m_rk[s] = '0;
`else
        chk("abort_rk00", 128'(rk1[0]), 128'(32'hF12186F9));
`endif
        chk_all("abort_all", 1'b0);
        kee = 1'b1;
        for (int c = 0; c < 40; c++) tick();
        chk("abort_idle_hold", 128'(rdy1), 128'(0));

        // Random keys with a stray load pulse during EXPAND
        for (int it = 0; it < 3; it++) begin
            rk_a = rand128();
            d_a  = 1'($urandom_range(0, 1));
            start(rk_a, d_a);
            for (int c = 0; c < 3; c++) tick();
            key  = rand128();
            dec  = ~d_a;
            load = 1'b1;
            tick();
            load = 1'b0;
            wait_ready(n);
            chk("rand_latency", 128'(n), 128'(28));
            model_rounds(rk_a, d_a, 32);
            chk_all("rand_all", 1'b0);
            $display("rand key=%h dec=%0d latency=%0d", rk_a, d_a, n + 4);
        end

        // Reset mid-EXPAND, then a full restart
        start(rand128(), 1'b0);
        for (int c = 0; c < 7; c++) tick();
        reset_n = 1'b0;
        #1;
        for (int s = 0; s < 32; s++) m_rk[s] = '0;
        chk("midreset_ready1", 128'(rdy1), 128'(0));
        chk("midreset_ready4", 128'(rdy4), 128'(0));
        chk_all("midreset_rk1", 1'b0);
        chk_all("midreset_rk4", 1'b1);
        tick();
        chk("midreset_hold_ready", 128'(rdy1), 128'(0));
        reset_n = 1'b1;
        tick();
        rk_a = rand128();
        start(rk_a, 1'b1);
        wait_ready(n);
        chk("postreset_latency", 128'(n), 128'(32));
        model_rounds(rk_a, 1'b1, 32);
        chk_all("postreset_all", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
